// File: rtl/column_frame_buffer.sv
// column_frame_buffer: multi-bank store of per-column raycast records.
// The HPS streams bus words over Avalon-MM. They are assembled into column records and committed into
// the write bank. Completed frames are queued as pending and promoted to the read bank at vblank.
module column_frame_buffer #(
  parameter int NUM_COLS      = 640,
  parameter int WORDS_PER_COL = 5,
  parameter int WORD_W        = 16,
  parameter int NUM_BANKS     = 3,
  parameter int COL_AW        = $clog2(NUM_COLS)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            chipselect,
  input  logic                            write,
  input  logic [1:0]                      address,
  input  logic [WORD_W-1:0]               writedata,
  output logic [WORD_W-1:0]               readdata,
  input  logic                            vblank_swap,
  input  logic                            rd_en,
  input  logic [COL_AW-1:0]               rd_col,
  output logic [WORDS_PER_COL*WORD_W-1:0] rd_data,
  output logic                            rd_valid
);

  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WIDX_W    = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
  localparam int REC_W     = WORDS_PER_COL * WORD_W;
  localparam int MEM_AW    = BANK_W + COL_AW;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [0:0] {COLLECT, COMMIT} state_t;

  state_t              state_reg, state_next;
  logic [WIDX_W-1:0]   word_idx_reg, word_idx_next;
  logic [COL_AW-1:0]   col_ptr_reg, col_ptr_next;
  logic [BANK_W-1:0]   read_bank_reg, read_bank_next, read_bank_mid;
  logic [BANK_W-1:0]   write_bank_reg, write_bank_next;
  logic [BANK_W-1:0]   pend_bank_reg, pend_bank_next;
  logic [BANK_W-1:0]   free_bank;
  logic                pending_reg, pending_next, pending_mid;
  logic [7:0]          drop_cnt_reg, drop_cnt_next;
  logic                rd_valid_reg;
  logic [REC_W-1:0]    rd_data_reg;
  logic [REC_W-1:0]    record;
  logic [WORD_W-1:0]   status;
  logic                data_wr, restart_wr, clear_wr;
  logic                commit, frame_done, swap, rd_in_range;

  logic [REC_W-1:0] mem [MEM_DEPTH];

  assign data_wr    = chipselect & write & (address == 2'd1);
  assign restart_wr = chipselect & write & (address == 2'd0);
  assign clear_wr   = chipselect & write & (address == 2'd3) & writedata[0];

  assign commit      = (state_reg == COMMIT);
  assign frame_done  = commit && ({1'b0, col_ptr_reg} == (COL_AW+1)'(NUM_COLS - 1));
  assign rd_in_range = ({1'b0, rd_col} < (COL_AW+1)'(NUM_COLS));

  // One lane register per bus word of the record; lane gi captures the data write addressed to it.
  for (genvar gi = 0; gi < WORDS_PER_COL; gi++) begin : g_lane
    logic [WORD_W-1:0] lane_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lane_reg <= '0;
      end else if (data_wr && word_idx_reg == WIDX_W'(gi)) begin
        lane_reg <= writedata;
      end
    end
    assign record[gi*WORD_W +: WORD_W] = lane_reg;
  end

  // Assembly FSM next state. word_idx is already 0 during COMMIT, so a data write in that cycle
  // simply becomes word 0 of the next record. Restart is applied after the commit bookkeeping.
  always_comb begin
    state_next    = COLLECT;
    word_idx_next = word_idx_reg;
    col_ptr_next  = col_ptr_reg;
    if (commit) begin
      col_ptr_next = frame_done ? '0 : col_ptr_reg + COL_AW'(1);
    end
    if (data_wr) begin
      if (word_idx_reg == WIDX_W'(WORDS_PER_COL - 1)) begin
        word_idx_next = '0;
        state_next    = COMMIT;
      end else begin
        word_idx_next = word_idx_reg + WIDX_W'(1);
      end
    end
    if (restart_wr) begin
      word_idx_next = '0;
      col_ptr_next  = '0;
    end
  end

  // The swap is resolved first; a frame completing in the same cycle is then evaluated against the post-swap banks.
  assign swap          = vblank_swap & pending_reg;
  assign read_bank_mid = swap ? pend_bank_reg : read_bank_reg;
  assign pending_mid   = swap ? 1'b0 : pending_reg;

  // Lowest bank index that is neither displayed nor about to become pending.
  always_comb begin
    free_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (BANK_W'(b) != read_bank_mid && BANK_W'(b) != write_bank_reg) free_bank = BANK_W'(b);
    end
  end

  // Bank rotation and drop counting. A frame is counted as dropped only when it displaces a pending
  // frame that the same-cycle swap did not consume. A clear overrides a coincident increment.
  always_comb begin
    read_bank_next  = read_bank_mid;
    pending_next    = pending_mid;
    pend_bank_next  = pend_bank_reg;
    write_bank_next = write_bank_reg;
    drop_cnt_next   = drop_cnt_reg;
    if (frame_done) begin
      if (pending_mid && drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
      pending_next    = 1'b1;
      pend_bank_next  = write_bank_reg;
      write_bank_next = free_bank;
    end
    if (clear_wr) drop_cnt_next = '0;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= COLLECT;
      word_idx_reg   <= '0;
      col_ptr_reg    <= '0;
      read_bank_reg  <= '0;
      write_bank_reg <= BANK_W'(1);
      pend_bank_reg  <= '0;
      pending_reg    <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      word_idx_reg   <= word_idx_next;
      col_ptr_reg    <= col_ptr_next;
      read_bank_reg  <= read_bank_next;
      write_bank_reg <= write_bank_next;
      pend_bank_reg  <= pend_bank_next;
      pending_reg    <= pending_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  // Record commit into the write bank; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) mem[{write_bank_reg, col_ptr_reg}] <= record;
  end

  // Registered read from the displayed bank; out-of-range columns read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= rd_in_range ? mem[{read_bank_reg, rd_col}] : '0;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

  // Status word and read mux.
  always_comb begin
    status        = '0;
    status[0]     = pending_reg;
    status[1]     = |drop_cnt_reg;
    status[3:2]   = read_bank_reg[1:0];
    status[5:4]   = write_bank_reg[1:0];
    status[15:8]  = drop_cnt_reg;
    readdata      = (address == 2'd2) ? status : '0;
  end

endmodule

// File: tb/tb_column_frame_buffer.sv
// Directed bench for column_frame_buffer: frame streaming, bank rotation, drops, restart, clear, reset.
module tb_column_frame_buffer;

  localparam int NUM_COLS = 640;
  localparam int WPC      = 5;
  localparam int WORD_W   = 16;
  localparam int NBANK    = 3;
  localparam int COL_AW   = 10;
  localparam int FRAME_W  = NUM_COLS * WPC;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              chipselect, write, vblank_swap, rd_en;
  logic [1:0]        address;
  logic [WORD_W-1:0] writedata, readdata;
  logic [COL_AW-1:0] rd_col;
  logic [WPC*WORD_W-1:0] rd_data;
  logic              rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  column_frame_buffer #(
    .NUM_COLS(NUM_COLS), .WORDS_PER_COL(WPC), .WORD_W(WORD_W), .NUM_BANKS(NBANK), .COL_AW(COL_AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .vblank_swap(vblank_swap), .rd_en(rd_en),
    .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h ok", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_of(int tag, int c, int k);
    return 16'(((tag & 3) << 14) | ((c & 1023) << 4) | (k & 15));
  endfunction

  function automatic logic [127:0] rec_of(int tag, int c);
    logic [127:0] r = '0;
    for (int k = 0; k < WPC; k++) r[k*16 +: 16] = word_of(tag, c, k);
    return r;
  endfunction

  // Back-to-back data writes for word indices [first, first+count); the trailing idle cycle
  // hosts the final COMMIT, optionally together with a vblank_swap pulse.
  task automatic stream(input int tag, input int first, input int count, input bit swap_at_end);
    for (int n = first; n < first + count; n++) begin
      chipselect = 1'b1; write = 1'b1; address = 2'd1;
      writedata = word_of(tag, n / WPC, n % WPC);
      tick();
    end
    chipselect = 1'b0; write = 1'b0; address = 2'd0;
    vblank_swap = swap_at_end;
    tick();
    vblank_swap = 1'b0;
  endtask

  task automatic avm_write(input logic [1:0] addr, input logic [15:0] data, input logic cs);
    chipselect = cs; write = 1'b1; address = addr; writedata = data;
    tick();
    chipselect = 1'b0; write = 1'b0; address = 2'd0;
  endtask

  task automatic check_status(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    logic [15:0] s;
    chipselect = 1'b1; address = 2'd2;
    #1;
    s = readdata;
    chipselect = 1'b0; address = 2'd0;
    check(tag, s & mask, exp & mask);
  endtask

  task automatic pulse_swap();
    vblank_swap = 1'b1;
    tick();
    vblank_swap = 1'b0;
  endtask

  task automatic check_col(input string tag, input int c, input logic [127:0] exp);
    rd_en = 1'b1; rd_col = COL_AW'(c);
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 128'(rd_valid), 128'd1);
    check({tag, "_data"}, 128'(rd_data), exp);
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; address = 2'd0; writedata = '0;
    vblank_swap = 1'b0; rd_en = 1'b0; rd_col = '0;
    tick(); tick(); tick();
    check("reset_rd_valid", 128'(rd_valid), 128'd0);
    check("reset_rd_data", 128'(rd_data), 128'd0);
    check_status("reset_status", 16'h0010, 16'hFFFF);
    reset_n = 1'b1;
    tick();

    // Frame 1 into bank 1; completion only on the very last word.
    stream(0, 0, FRAME_W - 1, 1'b0);
    check_status("t1_before_last", 16'h0010, 16'hFFFF);
    stream(0, FRAME_W - 1, 1, 1'b0);
    check_status("t1_pending", 16'h0021, 16'hFFFF);
    pulse_swap();
    check_status("t1_swapped", 16'h0024, 16'hFFFF);
    check_col("t1_col7", 7, rec_of(0, 7));
    tick();
    check("t1_valid_idle", 128'(rd_valid), 128'd0);
    check_col("t1_col640", 640, 128'd0);

    // Two frames before a swap: one drop, newest frame wins.
    stream(1, 0, FRAME_W, 1'b0);
    check_status("t2_first", 16'h0005, 16'hFFFF);
    stream(2, 0, FRAME_W, 1'b0);
    check_status("t2_drop", 16'h0127, 16'hFFFF);
    pulse_swap();
    check_status("t2_swapped", 16'h0122, 16'hFFFF);
    check_col("t2_col7", 7, rec_of(2, 7));
    check_col("t2_col639", 639, rec_of(2, 639));

    // Completion coinciding with vblank_swap while nothing was pending: no swap.
    stream(3, 0, FRAME_W, 1'b1);
    check_status("t3a_noswap", 16'h0113, 16'hFFFF);
    check_col("t3a_old", 7, rec_of(2, 7));
    pulse_swap();
    check_status("t3a_swapped", 16'h011A, 16'hFFFF);
    check_col("t3a_new", 7, rec_of(3, 7));

    // Completion coinciding with vblank_swap while a frame was pending.
    stream(0, 0, FRAME_W, 1'b0);
    check_status("t3b_pending", 16'h010B, 16'hFFFF);
    stream(1, 0, FRAME_W, 1'b1);
    check_status("t3b_same_cycle", 16'h0027, 16'h00FF);
    check_col("t3b_old_pend", 7, rec_of(0, 7));
    pulse_swap();
    check_status("t3b_swapped", 16'h0022, 16'h00FF);
    check_col("t3b_new", 7, rec_of(1, 7));

    // Drop counter clear: only a selected addr3 write with bit 0 set clears it.
    avm_write(2'd3, 16'h0000, 1'b1);
    check_status("clr_bit0_zero", 16'h0002, 16'h0002);
    avm_write(2'd3, 16'h0001, 1'b0);
    check_status("clr_no_cs", 16'h0002, 16'h0002);
    avm_write(2'd3, 16'h0001, 1'b1);
    check_status("clr_done", 16'h0020, 16'hFFFF);

    // Restart after 3 words of column 12: the next frame starts at column 0.
    stream(1, 0, 12 * WPC + 3, 1'b0);
    avm_write(2'd0, 16'h0000, 1'b1);
    check_status("t4_restart", 16'h0020, 16'hFFFF);
    stream(2, 0, FRAME_W - 1, 1'b0);
    check_status("t4_before_last", 16'h0020, 16'hFFFF);
    stream(2, FRAME_W - 1, 1, 1'b0);
    check_status("t4_pending", 16'h0011, 16'hFFFF);
    pulse_swap();
    check_status("t4_swapped", 16'h0018, 16'hFFFF);
    check_col("t4_col0", 0, rec_of(2, 0));
    check_col("t4_col12", 12, rec_of(2, 12));
    check_col("t4_col639", 639, rec_of(2, 639));

    // Reset mid-record and mid-read.
    stream(0, 0, 2, 1'b0);
    rd_en = 1'b1; rd_col = COL_AW'(7);
    tick();
    check("t6_pre_valid", 128'(rd_valid), 128'd1);
    check("t6_pre_data", 128'(rd_data), rec_of(2, 7));
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(rd_valid), 128'd0);
    check("t6_rst_data", 128'(rd_data), 128'd0);
    check_status("t6_rst_status", 16'h0010, 16'hFFFF);
    rd_en = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    stream(3, 0, FRAME_W - 1, 1'b0);
    check_status("t6_before_last", 16'h0010, 16'hFFFF);
    stream(3, FRAME_W - 1, 1, 1'b0);
    check_status("t6_pending", 16'h0021, 16'hFFFF);
    pulse_swap();
    check_status("t6_swapped", 16'h0024, 16'hFFFF);
    check_col("t6_col7", 7, rec_of(3, 7));
    check_col("t6_col0", 0, rec_of(3, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
